// File: rtl/ff_write_arbiter.sv
// Round-robin write-port arbiter for a single FF register: registered write enable/data plus an issued-write counter.
// Define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module ff_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 6,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          Clk_CI,
    input  logic                          Rst_RI,
    input  logic [NUM_REQ-1:0]            Req_SI,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] Data_DI,
    output logic [NUM_REQ-1:0]            Gnt_SO,
    output logic                          FfWrEn_SO,
    output logic [DATA_WIDTH-1:0]         FfD_DO,
    output logic                          Busy_SO,
    output logic [CNT_WIDTH-1:0]          WrCnt_DO
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]      ptr_reg, ptr_next;
    logic                  ff_wr_en_reg, ff_wr_en_next;
    logic [DATA_WIDTH-1:0] ff_d_reg, ff_d_next;
    logic                  busy_reg, busy_next;
    logic [CNT_WIDTH-1:0]  wr_cnt_reg, wr_cnt_next;

    logic                  gnt_valid;
    logic [PTR_W-1:0]      gnt_idx;
    logic [PTR_W:0]        rr_sum;
    logic [PTR_W-1:0]      rr_cand;
    logic [DATA_WIDTH-1:0] data_slice [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign data_slice[gi] = Data_DI[gi*DATA_WIDTH +: DATA_WIDTH];
            assign Gnt_SO[gi]     = gnt_valid && (gnt_idx == PTR_W'(gi));
        end
    endgenerate

    // Search upward from ptr_reg with wrap; first asserted request wins.
    // In the fixed-priority build ptr_reg stays 0, so this degenerates to lowest-index-first.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        rr_sum    = '0;
        rr_cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_sum = {1'b0, ptr_reg} + (PTR_W+1)'(k);
            if (rr_sum >= NUM_REQ_W) begin
                rr_sum = rr_sum - NUM_REQ_W;
            end
            rr_cand = rr_sum[PTR_W-1:0];
            if (!gnt_valid && Req_SI[rr_cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = rr_cand;
            end
        end
        // No grant may be observed (or acted on) while reset is held.
        if (Rst_RI) begin
            gnt_valid = 1'b0;
        end
    end

    always_comb begin
        ptr_next      = ptr_reg;
        ff_wr_en_next = 1'b0;
        busy_next     = 1'b0;
        ff_d_next     = ff_d_reg;
        wr_cnt_next   = wr_cnt_reg;
        if (gnt_valid) begin
            ptr_next      = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PTR_W'(1);
            ff_wr_en_next = 1'b1;
            busy_next     = 1'b1;
            ff_d_next     = data_slice[gnt_idx];
            wr_cnt_next   = wr_cnt_reg + CNT_WIDTH'(1);
        end
`ifdef ARB_FIXED_PRIO_EN
        ptr_next = '0;
`else
`endif
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            ptr_reg      <= '0;
            ff_wr_en_reg <= 1'b0;
            ff_d_reg     <= '0;
            busy_reg     <= 1'b0;
            wr_cnt_reg   <= '0;
        end else begin
            ptr_reg      <= ptr_next;
            ff_wr_en_reg <= ff_wr_en_next;
            ff_d_reg     <= ff_d_next;
            busy_reg     <= busy_next;
            wr_cnt_reg   <= wr_cnt_next;
        end
    end

    assign FfWrEn_SO = ff_wr_en_reg;
    assign FfD_DO    = ff_d_reg;
    assign Busy_SO   = busy_reg;
    assign WrCnt_DO  = wr_cnt_reg;

endmodule

// File: tb/tb_ff_write_arbiter.sv
// Directed bench for ff_write_arbiter; a second instance with CNT_WIDTH=3 exercises counter wrap.
module tb_ff_write_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [23:0] data;
    logic [3:0]  gnt, gnt3;
    logic        wr_en, wr_en3;
    logic [5:0]  ff_d, ff_d3;
    logic        busy, busy3;
    logic [7:0]  wr_cnt;
    logic [2:0]  wr_cnt3;

    int total = 0;
    int bad   = 0;

    ff_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(6), .CNT_WIDTH(8)) u_dut (
        .Clk_CI(clk), .Rst_RI(rst), .Req_SI(req), .Data_DI(data),
        .Gnt_SO(gnt), .FfWrEn_SO(wr_en), .FfD_DO(ff_d), .Busy_SO(busy), .WrCnt_DO(wr_cnt)
    );

    ff_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(6), .CNT_WIDTH(3)) u_dut3 (
        .Clk_CI(clk), .Rst_RI(rst), .Req_SI(req), .Data_DI(data),
        .Gnt_SO(gnt3), .FfWrEn_SO(wr_en3), .FfD_DO(ff_d3), .Busy_SO(busy3), .WrCnt_DO(wr_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves the bench at posedge+1 with reset released and no requests.
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req = 4'b0000;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req = 4'b1111;
        data = 24'hFFFFFF;
        @(negedge clk);
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=%b", gnt, 4'b0000); end
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wren got=%b exp=0", wr_en); end
        total++; if (wr_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", wr_cnt); end
        total++; if (ff_d !== 6'h00 || busy !== 1'b0) begin bad++; $display("FAIL reset_d_busy got d=%h busy=%b exp d=00 busy=0", ff_d, busy); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL reset_first_gnt got=%b exp=0001", gnt); end
        @(posedge clk); #1;
        req = 4'b0000;
        total++; if (wr_en !== 1'b1 || wr_cnt !== 8'd1) begin bad++; $display("FAIL reset_first_write got wren=%b cnt=%0d exp wren=1 cnt=1", wr_en, wr_cnt); end
        $display("test_reset done");
    endtask

    task automatic test_single_write();
        do_reset();
        req  = 4'b0100;
        data = 24'h000000;
        data[2*6 +: 6] = 6'h2A;
        data[0 +: 6]   = 6'h15;
        @(negedge clk);
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
        @(posedge clk); #1;
        req = 4'b0000;
        total++; if (wr_en !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL single_wren got wren=%b busy=%b exp 1/1", wr_en, busy); end
        total++; if (ff_d !== 6'h2A) begin bad++; $display("FAIL single_data got=%h exp=2a", ff_d); end
        total++; if (wr_cnt !== 8'd1) begin bad++; $display("FAIL single_cnt got=%0d exp=1", wr_cnt); end
        @(posedge clk); #1;
        total++; if (wr_en !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_idle got wren=%b busy=%b exp 0/0", wr_en, busy); end
        total++; if (ff_d !== 6'h2A) begin bad++; $display("FAIL single_hold got=%h exp=2a", ff_d); end
        $display("test_single_write done");
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        logic [5:0] exp_d;
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 4; i++) data[i*6 +: 6] = 6'h10 + 6'(i);
        for (int c = 0; c < 8; c++) begin
            exp_g = 4'b0001 << (c % 4);
            exp_d = 6'h10 + 6'(c % 4);
            @(negedge clk);
            total++; if (gnt !== exp_g) begin bad++; $display("FAIL rr_gnt cycle=%0d got=%b exp=%b", c, gnt, exp_g); end
            @(posedge clk); #1;
            total++; if (wr_en !== 1'b1 || ff_d !== exp_d || wr_cnt !== 8'(c + 1)) begin
                bad++; $display("FAIL rr_write cycle=%0d got wren=%b d=%h cnt=%0d exp wren=1 d=%h cnt=%0d", c, wr_en, ff_d, wr_cnt, exp_d, c + 1);
            end
            $display("rr cycle %0d gnt=%b d=%h cnt=%0d", c, exp_g, ff_d, wr_cnt);
        end
        req = 4'b0000;
        @(posedge clk); #1;
        total++; if (wr_en !== 1'b0 || wr_cnt !== 8'd8) begin bad++; $display("FAIL rr_end got wren=%b cnt=%0d exp wren=0 cnt=8", wr_en, wr_cnt); end
    endtask

    task automatic test_ptr_wrap();
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'b1000; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b1000; exp_seq[3] = 4'b0010;
        do_reset();
        req = 4'b1000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++; if (gnt !== exp_seq[c]) begin bad++; $display("FAIL ptr_gnt step=%0d got=%b exp=%b", c, gnt, exp_seq[c]); end
            $display("ptr step %0d gnt=%b", c, gnt);
            @(posedge clk); #1;
            req = 4'b1010;
        end
        req = 4'b0000;
    endtask

    task automatic test_drop();
        do_reset();
        req = 4'b0011;
        @(negedge clk);
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL drop_first got=%b exp=0001", gnt); end
        @(posedge clk); #1;
        req = 4'b0000;
        @(posedge clk); #1;
        total++; if (wr_en !== 1'b0 || wr_cnt !== 8'd1) begin bad++; $display("FAIL drop_nowrite got wren=%b cnt=%0d exp wren=0 cnt=1", wr_en, wr_cnt); end
        req = 4'b0101;
        @(negedge clk);
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL drop_ptr_hold got=%b exp=0100", gnt); end
        @(posedge clk); #1;
        req = 4'b0000;
        $display("test_drop done");
    endtask

    task automatic test_counter_wrap();
        logic [2:0] exp_c;
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            exp_c = 3'((c + 1) % 8);
            total++; if (wr_cnt3 !== exp_c) begin bad++; $display("FAIL cnt3 step=%0d got=%0d exp=%0d", c, wr_cnt3, exp_c); end
            $display("cnt3 step %0d cnt=%0d", c, wr_cnt3);
        end
        req = 4'b0000;
        total++; if (wr_cnt !== 8'd9) begin bad++; $display("FAIL cnt8 got=%0d exp=9", wr_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0100;
        data[2*6 +: 6] = 6'h33;
        @(posedge clk); #1;
        req = 4'b0000;
        rst = 1'b1;
        #1;
        total++; if (wr_en !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_async got wren=%b busy=%b exp 0/0", wr_en, busy); end
        total++; if (ff_d !== 6'h00 || wr_cnt !== 8'd0) begin bad++; $display("FAIL mid_clear got d=%h cnt=%0d exp d=00 cnt=0", ff_d, wr_cnt); end
        @(posedge clk); #1;
        rst = 1'b0;
        req = 4'b1111;
        @(negedge clk);
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL mid_ptr got=%b exp=0001", gnt); end
        @(posedge clk); #1;
        req = 4'b0000;
        $display("test_reset_mid done");
    endtask

    task automatic test_fixed_prio();
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL fixed_gnt cycle=%0d got=%b exp=0001", c, gnt); end
            @(posedge clk); #1;
            $display("fixed cycle %0d gnt=%b cnt=%0d", c, gnt, wr_cnt);
        end
        req = 4'b0000;
        total++; if (wr_cnt !== 8'd8 || wr_en !== 1'b1) begin bad++; $display("FAIL fixed_cnt got cnt=%0d wren=%b exp cnt=8 wren=1", wr_cnt, wr_en); end
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        data = 24'h000000;
        test_reset();
        test_single_write();
`ifdef ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_round_robin();
        test_ptr_wrap();
        test_drop();
`endif
        test_counter_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
